multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
// Multi-cycle control FSM for the execute datapath. Sequences fetch, decode, execute, memory and writeback.
// Drives ALUSrc/AluOp into ALUControl plus PC, IR, register-file and memory strobes.
// Uses ALUControl's zero flag to resolve branches and counts retired instructions.
// PARAMETERS
// TIMEOUT   16  max cycles waiting on mem_ready in FETCH/MEM before entering FAULT (>=1)
// CNT_W     32  width of retired-instruction counter
// PORTS
// clk         in   1      clock, rising edge
// reset       in   1      synchronous, active-high
// opcode      in   7      instr[6:0] from instruction register; sampled in DECODE only
// zero        in   1      ALUControl zero flag; sampled in EXEC for branches only
// mem_ready   in   1      memory completes current access this cycle
// mem_read    out  1      memory read request (held until mem_ready)
// mem_write   out  1      memory write request (held until mem_ready)
// i_or_d      out  1      0 = address from PC, 1 = address from ALU result
// ir_write    out  1      load instruction register (1-cycle pulse)
// pc_write    out  1      update PC (1-cycle pulse)
// pc_src      out  1      0 = PC+4, 1 = branch target
// ALUSrc      out  1      0 = inReg2, 1 = imm
// AluOp       out  2      0 = add, 1 = subtract, 2 = func3/func7 decode
// reg_write   out  1      register-file write enable (1-cycle pulse)
// mem_to_reg  out  1      writeback source: 0 = ALU result, 1 = memory data
// fault       out  1      sticky; set by illegal opcode or timeout
// state       out  3      current state: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 FAULT=7
// retired     out  CNT_W  retired-instruction count; wraps to 0
// BEHAVIOUR
// - Reset (synchronous): state=FETCH; retired=0; fault=0; class reg=0; wait counter=0.
//   All outputs are 0 while reset is high, including mem_read.
// - Outputs decode combinationally from registered state/class plus mem_ready/zero. Outputs not listed = 0.
// - Opcode classes, latched in DECODE:
//   R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011.
// - FETCH: mem_read=1, i_or_d=0.
//   On mem_ready: ir_write=1, pc_write=1, pc_src=0 -> DECODE.
// - DECODE: latch class -> EXEC. Any other opcode -> FAULT.
// - EXEC ALUSrc/AluOp by class:
//   R 0/2 -> WB; I 1/2 -> WB; LOAD/STORE 1/0 -> MEM.
//   BRANCH 0/1 -> FETCH, retire; if zero=1 also pc_write=1, pc_src=1 in the same cycle.
// - MEM: i_or_d=1; mem_read (LOAD) or mem_write (STORE) held until mem_ready.
//   On ready: LOAD -> WB; STORE -> FETCH, retire.
// - WB: reg_write=1; mem_to_reg=1 for LOAD -> FETCH, retire.
// - Retire: retired += 1 on the exit cycle; wraps from 2^CNT_W-1 to 0.
// - Wait counter: cleared on every state change; increments each cycle in FETCH/MEM without mem_ready.
//   When it reaches TIMEOUT without ready -> FAULT. mem_ready in the TIMEOUT-th waiting cycle still completes.
// - mem_ready outside FETCH/MEM is ignored. zero outside EXEC/BRANCH is ignored.
// - FAULT: all strobes 0; fault=1; retired frozen. Leave only via reset.
// - Reset mid-operation wins over any transition: no strobe, retire or PC write that cycle.
// - Latency with mem_ready=1 on first request: R/I 4 cycles, LOAD 5, STORE 4, BRANCH 3.
// TESTING
// - Reset, mem_ready=1, opcode=0110011: states 0,1,2,4,0.
//   EXEC: ALUSrc=0, AluOp=2. WB: reg_write=1. retired=1 after 4 cycles.
// - LOAD 0000011, mem_ready delayed 3 cycles in MEM:
//   mem_read and i_or_d=1 held 4 cycles; WB has mem_to_reg=1; retired +1.
// - BRANCH 1100011 with zero=1: EXEC has pc_write=1, pc_src=1, AluOp=1.
//   Repeat with zero=0: pc_write=0 in EXEC. Both retire in 3 cycles.
// - opcode=1111111 in DECODE: next state=7, fault=1. Held for 20 cycles with mem_ready toggling.
//   Reset returns to state 0 with fault=0.
// - mem_ready=0 in FETCH (TIMEOUT=16): FAULT entered after 16 waiting cycles.
//   Separately, mem_ready in the 16th cycle still proceeds to DECODE.
// - CNT_W=4: run 17 R-type instructions -> retired wraps to 1.
//   Assert reset mid-MEM -> all outputs 0 next cycle, state=FETCH, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory and
// writeback, drives the ALU/PC/IR/register-file/memory strobes, resolves
// branches from the ALU zero flag and counts retired instructions.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ALUSrc,
  output logic [1:0]       AluOp,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CL_R      = 3'd0,
    CL_I      = 3'd1,
    CL_LOAD   = 3'd2,
    CL_STORE  = 3'd3,
    CL_BRANCH = 3'd4
  } cls_t;

  state_t            state_reg, state_next;
  cls_t              cls_reg, cls_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [CNT_W-1:0]  retired_reg;
  logic              retire;

  // State, instruction class, wait counter and retire counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      cls_reg     <= CL_R;
      wait_reg    <= '0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      cls_reg   <= cls_next;
      wait_reg  <= wait_next;
      if (retire) begin
        retired_reg <= retired_reg + CNT_W'(1);
      end
    end
  end

  // Next-state, strobe decode and wait-counter update; reset forces outputs low
  always_comb begin
    state_next = state_reg;
    cls_next   = cls_reg;
    wait_next  = wait_reg;
    retire     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ALUSrc     = 1'b0;
    AluOp      = 2'd0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    fault      = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (wait_reg == WAIT_W'(TIMEOUT - 1)) begin
          state_next = S_FAULT;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        state_next = S_EXEC;
        case (opcode)
          7'b0110011: cls_next = CL_R;
          7'b0010011: cls_next = CL_I;
          7'b0000011: cls_next = CL_LOAD;
          7'b0100011: cls_next = CL_STORE;
          7'b1100011: cls_next = CL_BRANCH;
          default:    state_next = S_FAULT;
        endcase
      end
      S_EXEC: begin
        case (cls_reg)
          CL_R: begin
            AluOp      = 2'd2;
            state_next = S_WB;
          end
          CL_I: begin
            ALUSrc     = 1'b1;
            AluOp      = 2'd2;
            state_next = S_WB;
          end
          CL_LOAD, CL_STORE: begin
            ALUSrc     = 1'b1;
            state_next = S_MEM;
          end
          CL_BRANCH: begin
            // Taken branch loads the target in the same cycle the compare resolves
            AluOp      = 2'd1;
            pc_write   = zero;
            pc_src     = zero;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          default: state_next = S_FAULT;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (cls_reg == CL_LOAD);
        mem_write = (cls_reg == CL_STORE);
        if (mem_ready) begin
          if (cls_reg == CL_LOAD) begin
            state_next = S_WB;
          end else begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end else if (wait_reg == WAIT_W'(TIMEOUT - 1)) begin
          state_next = S_FAULT;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_reg == CL_LOAD);
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: state_next = S_FAULT;
    endcase

    // Waiting time is measured per state visit
    if (state_next != state_reg) begin
      wait_next = '0;
    end

    state   = state_reg;
    retired = retired_reg;

    if (reset) begin
      retire     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ALUSrc     = 1'b0;
      AluOp      = 2'd0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      fault      = 1'b0;
      state      = 3'd0;
      retired    = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle checks of state, the strobe
// vector and the retire count against hand-computed values.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src;
  logic       ALUSrc, reg_write, mem_to_reg, fault;
  logic [1:0] AluOp;
  logic [2:0] state;
  logic [3:0] retired;
  logic [11:0] sb_vec;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

  // Strobe vector: {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
  //                 ALUSrc, AluOp[1:0], reg_write, mem_to_reg, fault}
  localparam logic [11:0] SB_NONE = 12'h000, SB_FETCH_RDY = 12'h980, SB_FETCH_WAIT = 12'h800,
                          SB_EX_R = 12'h010, SB_EX_I = 12'h030, SB_EX_LS = 12'h020,
                          SB_EX_BR_T = 12'h0C8, SB_EX_BR_N = 12'h008,
                          SB_MEM_LD = 12'hA00, SB_MEM_ST = 12'h600,
                          SB_WB = 12'h004, SB_WB_LD = 12'h006, SB_FAULT = 12'h001;

  assign sb_vec = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
                   ALUSrc, AluOp, reg_write, mem_to_reg, fault};

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .ALUSrc(ALUSrc), .AluOp(AluOp),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .fault(fault), .state(state),
    .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Called just after a rising edge; checks the cycle at the falling edge,
  // then advances to just after the next rising edge.
  task automatic expect_cycle(input string tag, input int st, input logic [11:0] sb, input int ret);
    @(negedge clk);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_strobes"}, 32'(sb_vec), 32'(sb));
    check({tag, "_retired"}, 32'(retired), 32'(ret));
    $display("cycle %-10s state=%0d strobes=%03h retired=%0d", tag, state, sb_vec, retired);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    expect_cycle(tag, 0, SB_NONE, 0);
    reset = 1'b0;
  endtask

  task automatic run_rtype(input string tag, input int ret);
    opcode = OP_R;
    mem_ready = 1'b1;
    expect_cycle({tag, "_f"}, 0, SB_FETCH_RDY, ret);
    expect_cycle({tag, "_d"}, 1, SB_NONE, ret);
    expect_cycle({tag, "_x"}, 2, SB_EX_R, ret);
    expect_cycle({tag, "_w"}, 4, SB_WB, ret);
  endtask

  initial begin
    reset = 1'b1;
    opcode = 7'd0;
    zero = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_cycle("rst0", 0, SB_NONE, 0);
    do_reset("rst1");

    // R-type: 0,1,2,4 then back to fetch
    run_rtype("r", 0);

    // LOAD with three stalled memory cycles
    opcode = OP_LD;
    expect_cycle("ld_f", 0, SB_FETCH_RDY, 1);
    expect_cycle("ld_d", 1, SB_NONE, 1);
    expect_cycle("ld_x", 2, SB_EX_LS, 1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) expect_cycle("ld_mwait", 3, SB_MEM_LD, 1);
    mem_ready = 1'b1;
    expect_cycle("ld_mrdy", 3, SB_MEM_LD, 1);
    expect_cycle("ld_w", 4, SB_WB_LD, 1);

    // STORE
    opcode = OP_ST;
    expect_cycle("st_f", 0, SB_FETCH_RDY, 2);
    expect_cycle("st_d", 1, SB_NONE, 2);
    expect_cycle("st_x", 2, SB_EX_LS, 2);
    expect_cycle("st_m", 3, SB_MEM_ST, 2);

    // I-type
    opcode = OP_I;
    expect_cycle("i_f", 0, SB_FETCH_RDY, 3);
    expect_cycle("i_d", 1, SB_NONE, 3);
    expect_cycle("i_x", 2, SB_EX_I, 3);
    expect_cycle("i_w", 4, SB_WB, 3);

    // Branch taken (zero held high throughout; only EXEC may use it)
    opcode = OP_BR;
    zero = 1'b1;
    expect_cycle("bt_f", 0, SB_FETCH_RDY, 4);
    expect_cycle("bt_d", 1, SB_NONE, 4);
    expect_cycle("bt_x", 2, SB_EX_BR_T, 4);

    // Branch not taken
    zero = 1'b0;
    expect_cycle("bn_f", 0, SB_FETCH_RDY, 5);
    expect_cycle("bn_d", 1, SB_NONE, 5);
    expect_cycle("bn_x", 2, SB_EX_BR_N, 5);

    // Ready arriving in the 16th waiting fetch cycle still completes
    opcode = OP_R;
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) expect_cycle("edge_wait", 0, SB_FETCH_WAIT, 6);
    mem_ready = 1'b1;
    expect_cycle("edge_rdy", 0, SB_FETCH_RDY, 6);
    expect_cycle("edge_d", 1, SB_NONE, 6);
    expect_cycle("edge_x", 2, SB_EX_R, 6);
    expect_cycle("edge_w", 4, SB_WB, 6);

    // Fetch timeout: 16 waiting cycles then FAULT, counter frozen
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) expect_cycle("to_wait", 0, SB_FETCH_WAIT, 7);
    expect_cycle("to_fault0", 7, SB_FAULT, 7);
    mem_ready = 1'b1;
    expect_cycle("to_fault1", 7, SB_FAULT, 7);
    do_reset("to_rst");

    // Illegal opcode: FAULT held through mem_ready toggling
    opcode = OP_BAD;
    expect_cycle("bad_f", 0, SB_FETCH_RDY, 0);
    expect_cycle("bad_d", 1, SB_NONE, 0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      zero = i[1];
      expect_cycle("bad_hold", 7, SB_FAULT, 0);
    end
    zero = 1'b0;
    do_reset("bad_rst");
    mem_ready = 1'b1;
    expect_cycle("bad_post", 0, SB_FETCH_RDY, 0);
    do_reset("wrap_rst");

    // 17 R-type instructions on a 4-bit counter: wraps to 1
    for (int n = 0; n < 17; n++) run_rtype("wrap", n % 16);

    // Reset in the middle of a stalled LOAD memory access
    opcode = OP_LD;
    mem_ready = 1'b1;
    expect_cycle("mr_f", 0, SB_FETCH_RDY, 1);
    expect_cycle("mr_d", 1, SB_NONE, 1);
    expect_cycle("mr_x", 2, SB_EX_LS, 1);
    mem_ready = 1'b0;
    expect_cycle("mr_m", 3, SB_MEM_LD, 1);
    mem_ready = 1'b1;
    do_reset("mr_rst");
    expect_cycle("mr_post", 0, SB_FETCH_RDY, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
